// File: rtl/lsq_param.sv
// lsq_param: tag-indexed load/store queue with age-ordered store-to-load forwarding, commit-driven store drain and flush
module lsq_param #(
  parameter int DEPTH       = 32,
  parameter int TAG_W       = $clog2(DEPTH),
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int PREG_W      = 7,
  parameter int NUM_COMMITS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [TAG_W-1:0]             head_tag,
  input  logic                         issue_valid,
  input  logic [TAG_W-1:0]             issue_tag,
  input  logic                         issue_is_store,
  input  logic [1:0]                   issue_size,
  input  logic                         issue_unsigned,
  input  logic [PREG_W-1:0]            issue_reg_dst,
  output logic                         lsq_ready,
  input  logic                         req_valid,
  input  logic [TAG_W-1:0]             req_tag,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_data,
  input  logic [NUM_COMMITS-1:0]       commit_valid,
  input  logic [NUM_COMMITS*TAG_W-1:0] commit_tag,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic                         mem_req_we,
  output logic [ADDR_W-1:0]            mem_req_addr,
  output logic [DATA_W-1:0]            mem_req_data,
  output logic [1:0]                   mem_req_size,
  input  logic                         mem_resp_valid,
  input  logic [DATA_W-1:0]            mem_resp_data,
  output logic                         cdb_valid,
  output logic [TAG_W-1:0]             cdb_tag,
  output logic [PREG_W-1:0]            cdb_reg_dst,
  output logic [DATA_W-1:0]            cdb_data
);
  typedef enum logic [2:0] {IDLE, MEM_REQ, MEM_WAIT, CDB, DRAIN} state_t;
  state_t state_q;
  logic [DEPTH-1:0] occ_q, occ_d, st_q, st_d, uns_q, uns_d, av_q, av_d, cmt_q, cmt_d, rep_q, rep_d;
  logic [1:0]        sz_q   [DEPTH];
  logic [1:0]        sz_d   [DEPTH];
  logic [PREG_W-1:0] dst_q  [DEPTH];
  logic [PREG_W-1:0] dst_d  [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [TAG_W-1:0]  cur_q, a_t, b_t, c_t, d_t, t, u, ct;
  logic              cur_ld_q, kill_q, a_ok, b_ok, c_ok, d_ok, older_open, hit, fwd;
  logic              go_a, go_b, go_c, go_d, free_v;
  logic [DATA_W-1:0] c_data, fd;
  logic              mem_req_valid_q, mem_req_we_q, cdb_q;
  logic [ADDR_W-1:0] mem_req_addr_q;
  logic [DATA_W-1:0] mem_req_data_q, cdb_data_q;
  logic [1:0]        mem_req_size_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [PREG_W-1:0] cdb_reg_dst_q;

  function automatic logic [DATA_W-1:0] ext(input logic [DATA_W-1:0] v, input logic [1:0] s, input logic z);
    ext = s == 2'd0 ? {{(DATA_W-8){~z & v[7]}}, v[7:0]} :
          s == 2'd1 ? {{(DATA_W-16){~z & v[15]}}, v[15:0]} : v;
  endfunction

  assign lsq_ready     = !flush && !occ_q[issue_tag];
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_we    = mem_req_we_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_data  = mem_req_data_q;
  assign mem_req_size  = mem_req_size_q;
  assign cdb_valid     = cdb_q && !flush;
  assign cdb_tag       = cdb_tag_q;
  assign cdb_reg_dst   = cdb_reg_dst_q;
  assign cdb_data      = cdb_data_q;

  // Walk entries oldest-first; for each load, the inner scan keeps the youngest older same-word store.
  always_comb begin
    a_ok = 1'b0; b_ok = 1'b0; c_ok = 1'b0; d_ok = 1'b0;
    a_t = '0; b_t = '0; c_t = '0; d_t = '0; t = '0; u = '0;
    c_data = '0; fd = '0; hit = 1'b0; fwd = 1'b0; older_open = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      t = head_tag + TAG_W'(k);
      hit = 1'b0;
      fwd = 1'b0;
      fd = '0;
      for (int j = 0; j < DEPTH; j++) begin
        u = head_tag + TAG_W'(j);
        if (j < k && occ_q[u] && st_q[u] && addr_q[u][ADDR_W-1:2] == addr_q[t][ADDR_W-1:2]) begin
          hit = 1'b1;
          fwd = addr_q[u] == addr_q[t] && sz_q[u] >= sz_q[t];
          fd = data_q[u];
        end
      end
      if (occ_q[t] && st_q[t] && cmt_q[t] && !a_ok) begin
        a_ok = 1'b1;
        a_t = t;
      end
      if (occ_q[t] && st_q[t] && av_q[t] && !rep_q[t] && !b_ok) begin
        b_ok = 1'b1;
        b_t = t;
      end
      if (occ_q[t] && !st_q[t] && av_q[t] && !older_open) begin
        if (hit && fwd && !c_ok) begin
          c_ok = 1'b1;
          c_t = t;
          c_data = ext(fd, sz_q[t], uns_q[t]);
        end
        if (!hit && !d_ok) begin
          d_ok = 1'b1;
          d_t = t;
        end
      end
      if (occ_q[t] && st_q[t] && !av_q[t]) older_open = 1'b1;
    end
  end

  // A flush cycle may still start a committed-store write but never a broadcast.
  always_comb begin
    go_a   = state_q == IDLE && a_ok;
    go_b   = state_q == IDLE && !flush && !a_ok && b_ok;
    go_c   = state_q == IDLE && !flush && !a_ok && !b_ok && c_ok;
    go_d   = state_q == IDLE && !flush && !a_ok && !b_ok && !c_ok && d_ok;
    free_v = (state_q == MEM_REQ && mem_req_we_q && mem_req_ready) || (state_q == CDB && cur_ld_q);
  end

  always_comb begin
    occ_d = occ_q; st_d = st_q; uns_d = uns_q; av_d = av_q; cmt_d = cmt_q; rep_d = rep_q;
    sz_d = sz_q; dst_d = dst_q; addr_d = addr_q; data_d = data_q; ct = '0;
    for (int i = 0; i < NUM_COMMITS; i++) begin
      ct = commit_tag[i*TAG_W +: TAG_W];
      if (commit_valid[i] && occ_q[ct] && st_q[ct] && av_q[ct]) cmt_d[ct] = 1'b1;
    end
    if (req_valid && !flush && occ_q[req_tag]) begin
      av_d[req_tag] = 1'b1;
      addr_d[req_tag] = req_addr;
      data_d[req_tag] = req_data;
    end
    if (go_b) rep_d[b_t] = 1'b1;
    if (free_v) occ_d[cur_q] = 1'b0;
    if (issue_valid && lsq_ready) begin
      occ_d[issue_tag] = 1'b1;
      st_d[issue_tag]  = issue_is_store;
      uns_d[issue_tag] = issue_unsigned;
      sz_d[issue_tag]  = issue_size;
      dst_d[issue_tag] = issue_reg_dst;
      av_d[issue_tag]  = 1'b0;
      cmt_d[issue_tag] = 1'b0;
      rep_d[issue_tag] = 1'b0;
    end
    if (flush) occ_d = occ_d & st_d & cmt_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= '0; st_q <= '0; uns_q <= '0; av_q <= '0; cmt_q <= '0; rep_q <= '0;
    end else begin
      occ_q <= occ_d; st_q <= st_d; uns_q <= uns_d; av_q <= av_d; cmt_q <= cmt_d; rep_q <= rep_d;
    end
  end

  always_ff @(posedge clk) begin
    sz_q   <= sz_d;
    dst_q  <= dst_d;
    addr_q <= addr_d;
    data_q <= data_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q <= '0;
      cur_ld_q <= 1'b0;
      kill_q <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_req_we_q <= 1'b0;
      mem_req_addr_q <= '0;
      mem_req_data_q <= '0;
      mem_req_size_q <= '0;
      cdb_q <= 1'b0;
      cdb_tag_q <= '0;
      cdb_reg_dst_q <= '0;
      cdb_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (go_a || go_d) begin
            state_q <= MEM_REQ;
            cur_q <= go_a ? a_t : d_t;
            mem_req_valid_q <= 1'b1;
            mem_req_we_q <= go_a;
            mem_req_addr_q <= go_a ? addr_q[a_t] : addr_q[d_t];
            mem_req_data_q <= go_a ? data_q[a_t] : '0;
            mem_req_size_q <= go_a ? sz_q[a_t] : sz_q[d_t];
          end else if (go_b || go_c) begin
            state_q <= CDB;
            cur_q <= go_c ? c_t : b_t;
            cur_ld_q <= go_c;
            cdb_q <= 1'b1;
            cdb_tag_q <= go_c ? c_t : b_t;
            cdb_reg_dst_q <= go_c ? dst_q[c_t] : '0;
            cdb_data_q <= go_c ? c_data : '0;
          end
        end
        MEM_REQ: begin
          kill_q <= !mem_req_ready && (kill_q || flush);
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q <= mem_req_we_q ? IDLE : (kill_q || flush) ? DRAIN : MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (flush) state_q <= mem_resp_valid ? IDLE : DRAIN;
          else if (mem_resp_valid) begin
            state_q <= CDB;
            cur_ld_q <= 1'b1;
            cdb_q <= 1'b1;
            cdb_tag_q <= cur_q;
            cdb_reg_dst_q <= dst_q[cur_q];
            cdb_data_q <= ext(mem_resp_data, sz_q[cur_q], uns_q[cur_q]);
          end
        end
        CDB: begin
          state_q <= IDLE;
          cdb_q <= 1'b0;
          cur_ld_q <= 1'b0;
        end
        DRAIN: if (mem_resp_valid) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsq_param.sv
// tb_lsq_param: directed scoreboard bench; stimulus queues expected CDB/memory events, monitors pop and compare
module tb_lsq_param;
  logic clk = 0, reset = 1, flush = 0;
  logic [4:0] head_tag = 0, issue_tag = 0, req_tag = 0, cdb_tag;
  logic issue_valid = 0, issue_is_store = 0, issue_unsigned = 0, lsq_ready, req_valid = 0;
  logic [1:0] issue_size = 0, commit_valid = 0, mem_req_size;
  logic [6:0] issue_reg_dst = 0, cdb_reg_dst;
  logic [31:0] req_addr = 0, req_data = 0, mem_req_addr, mem_req_data, mem_resp_data = 0, cdb_data;
  logic [9:0] commit_tag = 0;
  logic mem_req_valid, mem_req_ready = 1, mem_req_we, mem_resp_valid = 0, cdb_valid;
  logic [43:0] cdb_exp[$];
  logic [66:0] mem_exp[$];
  logic [31:0] resp_q[$];
  logic [43:0] ce;
  logic [66:0] me, mg, held;
  logic stall_prev = 0;
  int total = 0, bad = 0, rd_cnt = 0, resp_delay = 2;

  always #5 clk = ~clk;

  lsq_param dut (
    .clk(clk), .reset(reset), .flush(flush), .head_tag(head_tag),
    .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_is_store(issue_is_store),
    .issue_size(issue_size), .issue_unsigned(issue_unsigned), .issue_reg_dst(issue_reg_dst),
    .lsq_ready(lsq_ready), .req_valid(req_valid), .req_tag(req_tag), .req_addr(req_addr),
    .req_data(req_data), .commit_valid(commit_valid), .commit_tag(commit_tag),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_size(mem_req_size),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_reg_dst(cdb_reg_dst), .cdb_data(cdb_data)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (cdb_valid) begin
        total++;
        if (cdb_exp.size() == 0) begin
          bad++;
          $display("FAIL cdb_unexpected: got tag=%0d dst=%0d data=%h, required no broadcast", cdb_tag, cdb_reg_dst, cdb_data);
        end else begin
          ce = cdb_exp.pop_front();
          if ({cdb_tag, cdb_reg_dst, cdb_data} !== ce) begin
            bad++;
            $display("FAIL cdb: got tag=%0d dst=%0d data=%h, required tag=%0d dst=%0d data=%h",
                     cdb_tag, cdb_reg_dst, cdb_data, ce[43:39], ce[38:32], ce[31:0]);
          end
        end
      end
      mg = {mem_req_we, mem_req_addr, mem_req_data, mem_req_size};
      if (stall_prev) begin
        total++;
        if (!mem_req_valid || mg !== held) begin
          bad++;
          $display("FAIL mem_hold: got valid=%b req=%h, required valid=1 req=%h", mem_req_valid, mg, held);
        end
      end
      stall_prev = mem_req_valid && !mem_req_ready;
      held = mg;
      if (mem_req_valid && mem_req_ready) begin
        total++;
        if (!mem_req_we) rd_cnt++;
        if (!mem_req_we) mg[33:2] = 32'h0;
        if (mem_exp.size() == 0) begin
          bad++;
          $display("FAIL mem_unexpected: got we=%b addr=%h size=%0d, required no request", mem_req_we, mem_req_addr, mem_req_size);
        end else begin
          me = mem_exp.pop_front();
          if (mg !== me) begin
            bad++;
            $display("FAIL mem: got we=%b addr=%h data=%h size=%0d, required we=%b addr=%h data=%h size=%0d",
                     mg[66], mg[65:34], mg[33:2], mg[1:0], me[66], me[65:34], me[33:2], me[1:0]);
          end
        end
      end
    end else stall_prev = 0;
  end

  initial forever begin
    @(negedge clk);
    if (!reset && mem_req_valid && mem_req_ready && !mem_req_we) begin
      repeat (resp_delay) @(posedge clk);
      #1 mem_resp_valid = 1;
      mem_resp_data = resp_q.size() != 0 ? resp_q.pop_front() : 32'h0;
      @(posedge clk);
      #1 mem_resp_valid = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h, required %h", nm, got, want);
    end
  endtask

  task automatic do_issue(input logic [4:0] tg, input logic s, input logic [1:0] z, input logic un, input logic [6:0] d);
    issue_valid = 1; issue_tag = tg; issue_is_store = s; issue_size = z; issue_unsigned = un; issue_reg_dst = d;
    #1 chk("issue_ready", {31'h0, lsq_ready}, 32'h1);
    cyc();
    issue_valid = 0;
  endtask

  task automatic do_req(input logic [4:0] tg, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1; req_tag = tg; req_addr = a; req_data = d;
    cyc();
    req_valid = 0;
  endtask

  task automatic do_commit(input logic [1:0] v, input logic [4:0] t0, input logic [4:0] t1);
    commit_valid = v; commit_tag = {t1, t0};
    cyc();
    commit_valid = 0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((cdb_exp.size() != 0 || mem_exp.size() != 0) && n < 300) begin
      cyc();
      n++;
    end
    repeat (4) cyc();
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL %s_timeout: got %0d cdb and %0d mem events outstanding, required 0", nm, cdb_exp.size(), mem_exp.size());
    end
  endtask

  task automatic wait_read(input int n0, input string nm);
    int n = 0;
    while (rd_cnt == n0 && n < 50) begin
      cyc();
      n++;
    end
    chk(nm, {31'h0, rd_cnt != n0}, 32'h1);
  endtask

  initial begin
    int n0;
    repeat (3) cyc();
    reset = 0;
    chk("rst_ready", {31'h0, lsq_ready}, 32'h1);
    chk("rst_mem_valid", {31'h0, mem_req_valid}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_req_we}, 32'h0);
    chk("rst_mem_addr", mem_req_addr, 32'h0);
    chk("rst_cdb_valid", {31'h0, cdb_valid}, 32'h0);
    chk("rst_cdb_data", cdb_data, 32'h0);

    head_tag = 3;
    do_issue(3, 1, 2, 0, 0);
    do_issue(4, 0, 2, 0, 10);
    cdb_exp.push_back({5'd3, 7'd0, 32'h0});
    cdb_exp.push_back({5'd4, 7'd10, 32'hDEADBEEF});
    do_req(3, 32'h100, 32'hDEADBEEF);
    do_req(4, 32'h100, 32'h0);
    repeat (6) cyc();
    mem_exp.push_back({1'b1, 32'h100, 32'hDEADBEEF, 2'd2});
    do_commit(2'b01, 3, 0);
    drain("t1");

    head_tag = 5;
    do_issue(5, 1, 0, 0, 0);
    do_issue(6, 0, 1, 0, 11);
    cdb_exp.push_back({5'd5, 7'd0, 32'h0});
    do_req(5, 32'h201, 32'h80);
    do_req(6, 32'h200, 32'h0);
    repeat (8) cyc();
    mem_exp.push_back({1'b1, 32'h201, 32'h80, 2'd0});
    mem_exp.push_back({1'b0, 32'h200, 32'h0, 2'd1});
    resp_q.push_back(32'h8012);
    cdb_exp.push_back({5'd6, 7'd11, 32'hFFFF8012});
    do_commit(2'b01, 5, 0);
    drain("t2");

    head_tag = 1;
    do_issue(1, 1, 2, 0, 0);
    do_issue(2, 0, 0, 1, 12);
    do_req(2, 32'h40, 32'h0);
    repeat (8) cyc();
    cdb_exp.push_back({5'd1, 7'd0, 32'h0});
    mem_exp.push_back({1'b0, 32'h40, 32'h0, 2'd0});
    resp_q.push_back(32'hABCDEFF0);
    cdb_exp.push_back({5'd2, 7'd12, 32'h000000F0});
    do_req(1, 32'h80, 32'h11223344);
    drain("t3a");
    mem_exp.push_back({1'b1, 32'h80, 32'h11223344, 2'd2});
    do_commit(2'b01, 1, 0);
    drain("t3b");

    head_tag = 30;
    do_issue(31, 1, 2, 0, 0);
    do_issue(0, 0, 2, 0, 13);
    do_issue(1, 1, 2, 0, 0);
    cdb_exp.push_back({5'd31, 7'd0, 32'h0});
    cdb_exp.push_back({5'd1, 7'd0, 32'h0});
    cdb_exp.push_back({5'd0, 7'd13, 32'hCAFEF00D});
    do_req(31, 32'h300, 32'hCAFEF00D);
    do_req(1, 32'h300, 32'h55555555);
    do_req(0, 32'h300, 32'h0);
    repeat (8) cyc();
    mem_exp.push_back({1'b1, 32'h300, 32'hCAFEF00D, 2'd2});
    mem_exp.push_back({1'b1, 32'h300, 32'h55555555, 2'd2});
    do_commit(2'b11, 31, 1);
    drain("t4");

    head_tag = 7;
    resp_delay = 6;
    do_issue(7, 1, 2, 0, 0);
    do_issue(8, 0, 2, 0, 14);
    cdb_exp.push_back({5'd7, 7'd0, 32'h0});
    mem_exp.push_back({1'b0, 32'h500, 32'h0, 2'd2});
    mem_exp.push_back({1'b1, 32'h400, 32'h0BADF00D, 2'd2});
    resp_q.push_back(32'h99999999);
    n0 = rd_cnt;
    do_req(7, 32'h400, 32'h0BADF00D);
    do_req(8, 32'h500, 32'h0);
    wait_read(n0, "t5_read_seen");
    do_commit(2'b01, 7, 0);
    flush = 1;
    issue_tag = 20;
    #1 chk("t5_flush_ready", {31'h0, lsq_ready}, 32'h0);
    cyc();
    flush = 0;
    drain("t5");

    head_tag = 9;
    resp_delay = 2;
    do_issue(9, 1, 2, 0, 0);
    do_issue(10, 1, 1, 0, 0);
    cdb_exp.push_back({5'd9, 7'd0, 32'h0});
    cdb_exp.push_back({5'd10, 7'd0, 32'h0});
    do_req(9, 32'h600, 32'h01010101);
    do_req(10, 32'h602, 32'h0000BEEF);
    repeat (6) cyc();
    mem_req_ready = 0;
    mem_exp.push_back({1'b1, 32'h600, 32'h01010101, 2'd2});
    mem_exp.push_back({1'b1, 32'h602, 32'h0000BEEF, 2'd1});
    do_commit(2'b11, 10, 9);
    repeat (5) cyc();
    chk("t6_stalled_valid", {31'h0, mem_req_valid}, 32'h1);
    mem_req_ready = 1;
    drain("t6");

    head_tag = 12;
    resp_delay = 3;
    do_issue(12, 0, 2, 0, 15);
    mem_exp.push_back({1'b0, 32'h700, 32'h0, 2'd2});
    resp_q.push_back(32'h77777777);
    n0 = rd_cnt;
    do_req(12, 32'h700, 32'h0);
    wait_read(n0, "t7_read_seen");
    reset = 1;
    cyc();
    reset = 0;
    issue_tag = 12;
    #1 chk("t7_ready_after_reset", {31'h0, lsq_ready}, 32'h1);
    chk("t7_mem_valid_after_reset", {31'h0, mem_req_valid}, 32'h0);
    repeat (8) cyc();
    drain("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
